// File: rtl/control_unit_types_pkg.sv
// Shared types and encodings for the multicycle MIPS control path.
// Select enums encode their reset/idle value as 0.
package control_unit_types_pkg;

    typedef enum logic [1:0] {RD = 2'd0, RT = 2'd1, R31 = 2'd2} regdst_t;
    typedef enum logic [1:0] {ALUO = 2'd0, DLOAD = 2'd1, NPC = 2'd2, PORTB = 2'd3} memtoreg_t;
    typedef enum logic [1:0] {ZEROEXT = 2'd0, SIGNEXT = 2'd1, SHAMEXT = 2'd2, LUIEXT = 2'd3} extop_t;

    typedef enum logic [4:0] {
        ORTYPE, OSL, OITYPE, OLUI, OBEQ, OBNE, OJ, OJR, OJAL,
        OLW, OSW, OLL, OSC, OHALT, OJUNK, OERROR14, OERROR15
    } opfunc_t;

    typedef logic [2:0] mcstate_t;
    localparam mcstate_t FETCH  = 3'd0;
    localparam mcstate_t DECODE = 3'd1;
    localparam mcstate_t EXEC   = 3'd2;
    localparam mcstate_t MEMACC = 3'd3;
    localparam mcstate_t WBACK  = 3'd4;
    localparam mcstate_t HALTED = 3'd5;
    localparam mcstate_t ERROR  = 3'd6;

    localparam logic [5:0] RTYPE = 6'h00, J     = 6'h02, JAL  = 6'h03, BEQ   = 6'h04;
    localparam logic [5:0] BNE   = 6'h05, ADDI  = 6'h08, ADDIU = 6'h09, SLTI = 6'h0A;
    localparam logic [5:0] SLTIU = 6'h0B, ANDI  = 6'h0C, ORI  = 6'h0D, XORI  = 6'h0E;
    localparam logic [5:0] LUI   = 6'h0F, COP0  = 6'h10, COP1 = 6'h11, COP2  = 6'h12;
    localparam logic [5:0] COP3  = 6'h13, LW    = 6'h23, SW   = 6'h2B, LL    = 6'h30;
    localparam logic [5:0] SC    = 6'h38, HALT  = 6'h3F;

    localparam logic [5:0] SLL = 6'h00, SRL = 6'h02, SRA = 6'h03, JR   = 6'h08;
    localparam logic [5:0] ADD = 6'h20, ADDU = 6'h21, SUB = 6'h22, SUBU = 6'h23;
    localparam logic [5:0] AND = 6'h24, OR  = 6'h25, XOR = 6'h26, NOR  = 6'h27;
    localparam logic [5:0] SLT = 6'h2A, SLTU = 6'h2B;

    function automatic logic is_mem(input opfunc_t f);
        return (f == OLW) || (f == OSW) || (f == OLL) || (f == OSC);
    endfunction

endpackage

// File: rtl/opfunc_decode.sv
// Combinational IR classifier: opcode/funct -> opfunc_t plus zero-extend I-type flag.
// LL/SC are recognised only when MC_LLSC_EN is defined; otherwise they fall to OJUNK.
module opfunc_decode
    import control_unit_types_pkg::*;
#(
    parameter int IWIDTH = 32
) (
    input  logic [IWIDTH-1:0] ir,
    output opfunc_t           opfunc,
    output logic              zext
);

    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = ir[IWIDTH-1 -: 6];
    assign funct  = ir[5:0];

    wire unused_ir_mid = ^ir[IWIDTH-7:6];

    always_comb begin
        opfunc = OJUNK;
        zext   = 1'b0;
        case (opcode)
            RTYPE: begin
                case (funct)
                    SLL, SRL, SRA:                  opfunc = OSL;
                    JR:                             opfunc = OJR;
                    ADD, ADDU, SUB, SUBU, AND, OR,
                    XOR, NOR, SLT, SLTU:            opfunc = ORTYPE;
                    default:                        opfunc = OERROR14;
                endcase
            end
            ADDI, ADDIU, SLTI, SLTIU: opfunc = OITYPE;
            ANDI, ORI, XORI: begin
                opfunc = OITYPE;
                zext   = 1'b1;
            end
            LUI:  opfunc = OLUI;
            BEQ:  opfunc = OBEQ;
            BNE:  opfunc = OBNE;
            J:    opfunc = OJ;
            JAL:  opfunc = OJAL;
            LW:   opfunc = OLW;
            SW:   opfunc = OSW;
`ifdef MC_LLSC_EN
            LL:   opfunc = OLL;
            SC:   opfunc = OSC;
`endif
            HALT: opfunc = OHALT;
            COP0, COP1, COP2, COP3: opfunc = OERROR15;
            default: opfunc = OJUNK;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM; waits on ihit/dhit with a WAIT_MAX-cycle timeout into ERROR.
// LL/SC link tracking is built only when MC_LLSC_EN is defined.
module mc_control_fsm
    import control_unit_types_pkg::*;
#(
    parameter int IWIDTH   = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [IWIDTH-1:0] instr,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              zero,
    input  logic              link_clr,
    output logic              iREN,
    output logic              dREN,
    output logic              dWEN,
    output logic              ir_wen,
    output logic              pc_wen,
    output logic [1:0]        pcsrc,
    output logic              regwr,
    output regdst_t           regdst,
    output memtoreg_t         memtoreg,
    output extop_t            extop,
    output logic              alusrc,
    output logic              sc_result,
    output logic              halt,
    output logic              timeout
);

    localparam int CW = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

    mcstate_t          state_q, state_d;
    logic [IWIDTH-1:0] ir_q, ir_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              timeout_q, timeout_d;
    logic              link_q, link_d;
    logic              sc_ok_q, sc_ok_d;
    logic              wait_hit;
    opfunc_t           opfunc;
    logic              zext;
    extop_t            ext_sel;
    logic              alu_b;

    opfunc_decode #(.IWIDTH(IWIDTH)) u_opfunc_decode (
        .ir     (ir_q),
        .opfunc (opfunc),
        .zext   (zext)
    );

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        cnt_d     = '0;
        timeout_d = timeout_q;
        link_d    = link_q;
        sc_ok_d   = sc_ok_q;
        wait_hit  = (state_q == FETCH) ? ihit : dhit;
`ifdef MC_LLSC_EN
        if (link_clr) link_d = 1'b0;
`endif
        case (state_q)
            FETCH, MEMACC: begin
                if (wait_hit) begin
                    if (state_q == FETCH) begin
                        ir_d    = instr;
                        state_d = DECODE;
                    end else begin
                        state_d = (opfunc == OSW) ? FETCH : WBACK;
                        // LL set is applied last so it beats a same-cycle snoop clear
                        if (opfunc == OLL) link_d = 1'b1;
                        else if (opfunc == OSW || opfunc == OSC) link_d = 1'b0;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ERROR;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DECODE: begin
                if (opfunc == OHALT) state_d = HALTED;
                else if (opfunc == OJUNK || opfunc == OERROR14 || opfunc == OERROR15) state_d = ERROR;
                else state_d = EXEC;
            end
            EXEC: begin
                case (opfunc)
                    OBEQ, OBNE, OJ, OJR: state_d = FETCH;
                    OLW, OSW, OLL:       state_d = MEMACC;
                    OSC: begin
                        sc_ok_d = link_q;
                        state_d = link_q ? MEMACC : WBACK;
                    end
                    default:             state_d = WBACK;
                endcase
            end
            WBACK:         state_d = FETCH;
            HALTED, ERROR: state_d = state_q;
            default:       state_d = ERROR;
        endcase
`ifndef MC_LLSC_EN
        link_d  = 1'b0;
        sc_ok_d = 1'b0;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= FETCH;
            ir_q      <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            link_q    <= 1'b0;
            sc_ok_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            link_q    <= link_d;
            sc_ok_q   <= sc_ok_d;
        end
    end

    always_comb begin
        ext_sel = SIGNEXT;
        if (opfunc == OSL) ext_sel = SHAMEXT;
        else if (opfunc == OLUI) ext_sel = LUIEXT;
        else if (opfunc == OITYPE && zext) ext_sel = ZEROEXT;
        alu_b = (opfunc == OITYPE) || (opfunc == OLUI) || is_mem(opfunc);
    end

    // Outputs are held at their idle values while RST is asserted.
    always_comb begin
        iREN     = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        ir_wen   = 1'b0;
        pc_wen   = 1'b0;
        pcsrc    = 2'd0;
        regwr    = 1'b0;
        regdst   = RD;
        memtoreg = ALUO;
        extop    = ZEROEXT;
        alusrc   = 1'b0;
        halt     = 1'b0;
        timeout  = 1'b0;
        if (!RST) begin
            timeout = timeout_q;
            if (state_q == EXEC || state_q == MEMACC || state_q == WBACK) begin
                extop  = ext_sel;
                alusrc = alu_b;
            end
            case (state_q)
                FETCH: begin
                    iREN   = 1'b1;
                    ir_wen = ihit;
                    pc_wen = ihit;
                end
                EXEC: begin
                    case (opfunc)
                        OBEQ:    begin pc_wen = zero;  pcsrc = 2'd1; end
                        OBNE:    begin pc_wen = !zero; pcsrc = 2'd1; end
                        OJ, OJAL: begin pc_wen = 1'b1; pcsrc = 2'd2; end
                        OJR:     begin pc_wen = 1'b1;  pcsrc = 2'd3; end
                        default: ;
                    endcase
                end
                MEMACC: begin
                    dREN = (opfunc == OLW) || (opfunc == OLL);
                    dWEN = (opfunc == OSW) || (opfunc == OSC);
                end
                WBACK: begin
                    regwr = 1'b1;
                    if (opfunc == OJAL) regdst = R31;
                    else if (opfunc == ORTYPE || opfunc == OSL) regdst = RD;
                    else regdst = RT;
                    if (opfunc == OLW || opfunc == OLL) memtoreg = DLOAD;
                    else if (opfunc == OJAL) memtoreg = NPC;
                    else if (opfunc == OSC) memtoreg = PORTB;
                end
                HALTED, ERROR: halt = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MC_LLSC_EN
    assign sc_result = !RST && (state_q == WBACK) && (opfunc == OSC) && sc_ok_q;
`else
    assign sc_result = 1'b0;
    wire unused_llsc = link_clr ^ sc_ok_q;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: a default instance plus a WAIT_MAX=3 instance for timeout cases.
module tb_mc_control_fsm;
    import control_unit_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] instr = '0;
    logic        ihit = 1'b0, dhit = 1'b0, zero = 1'b0, link_clr = 1'b0;

    logic iREN, dREN, dWEN, ir_wen, pc_wen, regwr, alusrc, sc_result, halt, timeout;
    logic [1:0] pcsrc;
    regdst_t regdst;
    memtoreg_t memtoreg;
    extop_t extop;

    logic t_iREN, t_dREN, t_dWEN, t_ir_wen, t_pc_wen, t_regwr, t_alusrc, t_sc_result, t_halt, t_timeout;
    logic [1:0] t_pcsrc;
    regdst_t t_regdst;
    memtoreg_t t_memtoreg;
    extop_t t_extop;

    int n_chk = 0;
    int n_bad = 0;

    localparam logic [31:0] I_ADDU = 32'h00431021;
    localparam logic [31:0] I_LW   = 32'h8C430004;
    localparam logic [31:0] I_SW   = 32'hAC430004;
    localparam logic [31:0] I_BEQ  = 32'h10430003;
    localparam logic [31:0] I_BNE  = 32'h14430003;
    localparam logic [31:0] I_JAL  = 32'h0C000010;
    localparam logic [31:0] I_HALT = 32'hFC000000;
    localparam logic [31:0] I_JUNK = 32'hF8000000;
    localparam logic [31:0] I_LL   = 32'hC0430000;
    localparam logic [31:0] I_SC   = 32'hE0430000;

    mc_control_fsm #(.IWIDTH(32), .WAIT_MAX(15)) dut (
        .CLK(CLK), .RST(RST), .instr(instr), .ihit(ihit), .dhit(dhit), .zero(zero),
        .link_clr(link_clr), .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .ir_wen(ir_wen),
        .pc_wen(pc_wen), .pcsrc(pcsrc), .regwr(regwr), .regdst(regdst), .memtoreg(memtoreg),
        .extop(extop), .alusrc(alusrc), .sc_result(sc_result), .halt(halt), .timeout(timeout)
    );

    mc_control_fsm #(.IWIDTH(32), .WAIT_MAX(3)) dut_t (
        .CLK(CLK), .RST(RST), .instr(instr), .ihit(ihit), .dhit(dhit), .zero(zero),
        .link_clr(link_clr), .iREN(t_iREN), .dREN(t_dREN), .dWEN(t_dWEN), .ir_wen(t_ir_wen),
        .pc_wen(t_pc_wen), .pcsrc(t_pcsrc), .regwr(t_regwr), .regdst(t_regdst),
        .memtoreg(t_memtoreg), .extop(t_extop), .alusrc(t_alusrc), .sc_result(t_sc_result),
        .halt(t_halt), .timeout(t_timeout)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic ih, input logic dh, input logic z, input logic lc);
        ihit = ih; dhit = dh; zero = z; link_clr = lc;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_iren", iREN, 1'b0);
        chk("rst_halt", halt, 1'b0);
        chk("rst_sel", {regdst, memtoreg, extop}, {RD, ALUO, ZEROEXT});
        tick();
        RST = 1'b0;
    endtask

    // Runs FETCH (with waits) and DECODE; returns at the first cycle after DECODE.
    task automatic do_fetch(input logic [31:0] w, input int waits);
        instr = w;
        for (int i = 0; i < waits; i++) begin
            set_in(1'b0, 1'b0, 1'b0, 1'b0);
            chk("fetch_wait_iren", iREN, 1'b1);
            chk("fetch_wait_irwen", ir_wen, 1'b0);
            tick();
        end
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        chk("fetch_hit_strobes", {iREN, ir_wen, pc_wen, pcsrc}, {1'b1, 1'b1, 1'b1, 2'd0});
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        chk("decode_idle", {iREN, ir_wen, pc_wen, regwr}, 4'b0000);
        tick();
    endtask

    task automatic run_ll(input logic lc_at_hit);
        do_fetch(I_LL, 0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ll_exec_ext", {extop, alusrc}, {SIGNEXT, 1'b1});
        tick();
        set_in(1'b0, 1'b1, 1'b0, lc_at_hit);
        chk("ll_dren", dREN, 1'b1);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ll_wb", {regwr, memtoreg}, {1'b1, DLOAD});
        tick();
    endtask

    task automatic run_sc(input logic exp_ok);
        do_fetch(I_SC, 0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        if (exp_ok) begin
            set_in(1'b0, 1'b1, 1'b0, 1'b0);
            chk("sc_dwen", dWEN, 1'b1);
            tick();
            set_in(1'b0, 1'b0, 1'b0, 1'b0);
            chk("sc_ok_wb", {regwr, sc_result, memtoreg}, {1'b1, 1'b1, PORTB});
        end else begin
            chk("sc_fail_wb", {regwr, dWEN, sc_result}, {1'b1, 1'b0, 1'b0});
        end
        tick();
    endtask

    initial begin
        @(negedge CLK);
        do_reset();

        // ADDU with two fetch wait cycles
        do_fetch(I_ADDU, 2);
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        chk("addu_exec_regwr", regwr, 1'b0);
        tick();
        chk("addu_wb", {regwr, regdst, memtoreg}, {1'b1, RD, ALUO});
        tick();
        chk("addu_back_fetch", {iREN, regwr}, 2'b10);

        // LW, dhit on the 4th MEMACC cycle
        do_fetch(I_LW, 0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        chk("lw_exec_ext", {extop, alusrc}, {SIGNEXT, 1'b1});
        tick();
        for (int c = 1; c <= 4; c++) begin
            set_in(1'b0, (c == 4), 1'b0, 1'b0);
            chk("lw_memacc_dren", {dREN, dWEN}, 2'b10);
            tick();
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        chk("lw_wb", {regwr, dREN, memtoreg, regdst}, {1'b1, 1'b0, DLOAD, RT});
        tick();

        // BEQ taken, BNE not taken, both with zero=1
        do_fetch(I_BEQ, 0);
        set_in(1'b0, 1'b0, 1'b1, 1'b0);
        chk("beq_taken", {pc_wen, pcsrc}, {1'b1, 2'd1});
        tick();
        do_fetch(I_BNE, 1);
        set_in(1'b0, 1'b0, 1'b1, 1'b0);
        chk("bne_not_taken", pc_wen, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        chk("bne_back_fetch", iREN, 1'b1);

`ifdef MC_LLSC_EN
        run_ll(1'b0);
        run_sc(1'b1);
        run_ll(1'b0);
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        run_sc(1'b0);
        run_ll(1'b1);
        run_sc(1'b1);
`else
        do_fetch(I_LL, 0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ll_disabled_error", {halt, iREN, sc_result, timeout}, 4'b1000);
`endif

        // JAL then HALT
        do_reset();
        do_fetch(I_JAL, 0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        chk("jal_exec", {pc_wen, pcsrc}, {1'b1, 2'd2});
        tick();
        chk("jal_wb", {regwr, regdst, memtoreg}, {1'b1, R31, NPC});
        tick();
        do_fetch(I_HALT, 0);
        for (int i = 0; i < 4; i++) begin
            set_in(i[0], 1'b0, 1'b0, 1'b0);
            chk("halted_sticky", {halt, iREN, ir_wen, pc_wen, timeout}, 5'b10000);
            tick();
        end

        // Unknown opcode
        do_reset();
        do_fetch(I_JUNK, 0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        chk("junk_error", {halt, timeout, iREN}, 3'b100);

        // Timeout with WAIT_MAX=3 on the second instance
        do_reset();
        do_fetch(I_SW, 0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int c = 1; c <= 3; c++) begin
            set_in(1'b0, 1'b0, 1'b0, 1'b0);
            chk("t_memacc_dwen", {t_dWEN, t_halt}, 2'b10);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            set_in(1'b0, (i == 1), 1'b0, 1'b0);
            chk("t_timeout_sticky", {t_timeout, t_halt, t_dWEN, t_iREN}, 4'b1100);
            chk("main_no_timeout", {timeout, dWEN}, 2'b01);
            tick();
        end
        RST = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t_rst_outputs", {t_timeout, t_halt, t_iREN, t_dWEN, t_regwr}, 5'b00000);
        tick();
        RST = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t_after_rst_fetch", {t_iREN, t_timeout, t_halt}, 3'b100);

        // Hit on the cycle the count reaches WAIT_MAX wins
        do_fetch(I_SW, 0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int c = 1; c <= 3; c++) begin
            set_in(1'b0, (c == 3), 1'b0, 1'b0);
            chk("t_edge_dwen", t_dWEN, 1'b1);
            tick();
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t_edge_hit_wins", {t_iREN, t_timeout, t_halt}, 3'b100);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
